global_param_regs: RTL and testbench
====================================

# global_param_regs

Parametrised global-register loader and object sequencer for the render pipeline. In load mode (`status`=0) it parses a little-endian header byte stream: an object count, then `NUM_FIELDS` global parameters such as centre X/Y, angle and zoom. Parsed values go into shadow registers and commit atomically on the last header byte. In render mode (`status`=1) it counts objects down on `next` and raises `finish` when none remain.

## Interface
Parameters:
- `NUM_FIELDS`, default 4: number of global parameter fields after the count.
- `FIELD_BYTES`, default 1: bytes per field; `FIELD_W` = 8·`FIELD_BYTES`.
- `CNT_BYTES`, default 1: bytes in the object-count field; `OBJ_W` = 8·`CNT_BYTES`.

Derived: `TOTAL` = `CNT_BYTES` + `NUM_FIELDS`·`FIELD_BYTES`; `IDX_W` = max(1, clog2(`TOTAL`)).

Ports:
- `ACLK`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high; clock `ACLK`.
- `status`  in  1: 0 = load mode, 1 = render mode.
- `rd_valid`  in  1: header byte present on `rd_data`.
- `rd_data`  in  8: header byte.
- `rd_ready`  out  1: `~status`, combinational.
- `next`  in  1: one object consumed (render mode only).
- `fields`  out  `NUM_FIELDS`·`FIELD_W`: committed fields; field k occupies bits [k·`FIELD_W` +: `FIELD_W`].
- `obj_count`  out  `OBJ_W`: remaining objects.
- `byte_idx`  out  `IDX_W`: index of the next header byte expected.
- `load_done`  out  1: one-cycle pulse after commit.
- `loaded`  out  1: sticky; at least one complete header has committed.
- `finish`  out  1: `loaded` && `obj_count`==0.
- `abort`  out  1: one-cycle pulse; partial header discarded.
- `underflow`  out  1: one-cycle pulse; `next` arrived with `obj_count`==0.

## Operation
- A byte is accepted on a rising edge when `status`=0 && `rd_valid`=1.
- Each accepted byte is written into the shadow register at offset `byte_idx`, then `byte_idx` increments.
- Byte order: count bytes first, LSB first. Then field 0 .. field `NUM_FIELDS`-1, each LSB first.
- Commit, when the accepted byte is at `byte_idx`=`TOTAL`-1:
  - shadow → `fields` and `obj_count` in the same edge;
  - `byte_idx` → 0, `loaded` → 1, `load_done` pulses.
- Outputs never show a partially loaded header.
- Abort: `status` rises while `byte_idx`≠0.
  - `byte_idx` → 0, shadow discarded, `abort` pulses.
  - Committed `fields`, `obj_count` and `loaded` are unchanged.
- Render: `status`=1 && `next`=1.
  - If `obj_count`>0: decrement by 1. No wrap.
  - If `obj_count`==0: hold at 0 and pulse `underflow`.
- `next` is ignored while `status`=0. `rd_valid` is ignored while `status`=1.
- A new load after a render phase keeps the old committed values until the new header commits.
- Header count of 0: `finish` asserts immediately after commit.

## Timing
- Reset values: `fields`=0, `obj_count`=0, `byte_idx`=0, and `loaded`, `load_done`, `finish`, `abort`, `underflow` all 0.
- Reset mid-load discards everything; no `abort` pulse.
- Commit latency: values are visible in the cycle after the edge that accepts the last byte. `load_done` is high for exactly that cycle.
- `finish` is registered and computed from next-state values. It goes high in the same cycle that `obj_count` first reads 0, and drops in the same cycle a nonzero count commits.
- `abort` and `underflow` are high for exactly the cycle after the causing edge.
- Throughput: one byte per cycle with no bubbles. A header completes in `TOTAL` cycles.
- Back-to-back headers: the first byte of the next header can be accepted on the edge immediately after a commit.

## Structure
- Shared package `global_regs_pkg`:
  - state enum `{ST_LOAD, ST_RENDER}`;
  - helper function computing `TOTAL`;
  - `BYTE_W`=8.
- One sub-module, `gr_shadow_bank`: `TOTAL`×8 shadow byte array with indexed write, plus a flattened read-out to `obj_count`/`fields`.
- Top level holds `byte_idx`, commit/abort control, the down-counter and the pulse outputs.

## Test plan
- Defaults, stream 03,10,20,30,40 → `obj_count`=3, `fields`=0x40302010, `load_done` pulse, `loaded`=1, `finish`=0.
- After that load, `status`=1 and 3 `next` pulses → `obj_count` 2,1,0; `finish` rises with 0; a 4th `next` → `underflow` pulse, count stays 0.
- 2 bytes of a new header, then `status`→1 → `abort` pulse, `byte_idx`=0, previous `fields` and `obj_count` unchanged.
- `FIELD_BYTES`=2, `CNT_BYTES`=2, `NUM_FIELDS`=2, stream 00,01,34,12,78,56 → `obj_count`=0x0100, field0=0x1234, field1=0x5678.
- Count byte 00 → `finish`=1 in the cycle after commit. Two back-to-back headers with `rd_valid` held high → two `load_done` pulses `TOTAL` cycles apart.
- Reset asserted at `byte_idx`=3 → all outputs return to reset values and no `abort` pulse occurs.

Source files
------------

// File: rtl/global_regs_pkg.sv
// Shared types and sizing helpers for the global-register loader.
package global_regs_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ST_LOAD   = 1'b0,
    ST_RENDER = 1'b1
  } gr_state_e;

  function automatic int unsigned total_bytes(input int unsigned cnt_bytes,
                                              input int unsigned num_fields,
                                              input int unsigned field_bytes);
    return cnt_bytes + num_fields * field_bytes;
  endfunction

endpackage

// File: rtl/gr_shadow_bank.sv
// Shadow byte array for the header under construction; read-out includes the
// byte being written this cycle so the final byte can commit on the same edge.
module gr_shadow_bank
  import global_regs_pkg::*;
#(
  parameter int unsigned TOTAL = 5,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned OBJ_W = 8
) (
  input  logic                          ACLK,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [BYTE_W-1:0]             wr_data,
  input  logic                          clr,
  output logic [OBJ_W-1:0]              rd_obj_count,
  output logic [TOTAL*BYTE_W-OBJ_W-1:0] rd_fields
);

  logic [TOTAL*BYTE_W-1:0] shadow_q;
  logic [TOTAL*BYTE_W-1:0] merged;

  always_comb begin
    merged = shadow_q;
    if (wr_en && (32'(wr_idx) < TOTAL)) begin
      merged[32'(wr_idx)*BYTE_W +: BYTE_W] = wr_data;
    end
  end

  always_ff @(posedge ACLK) begin
    if (reset || clr) begin
      shadow_q <= '0;
    end else if (wr_en) begin
      shadow_q <= merged;
    end
  end

  assign rd_obj_count = merged[OBJ_W-1:0];
  assign rd_fields    = merged[TOTAL*BYTE_W-1:OBJ_W];

endmodule

// File: rtl/global_param_regs.sv
// Global-register header loader with atomic commit, plus render-mode object
// down-counter with finish/underflow/abort status.
module global_param_regs
  import global_regs_pkg::*;
#(
  parameter int unsigned NUM_FIELDS  = 4,
  parameter int unsigned FIELD_BYTES = 1,
  parameter int unsigned CNT_BYTES   = 1,
  localparam int unsigned FIELD_W = BYTE_W * FIELD_BYTES,
  localparam int unsigned OBJ_W   = BYTE_W * CNT_BYTES,
  localparam int unsigned TOTAL   = total_bytes(CNT_BYTES, NUM_FIELDS, FIELD_BYTES),
  localparam int unsigned IDX_W   = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
  input  logic                          ACLK,
  input  logic                          reset,
  input  logic                          status,
  input  logic                          rd_valid,
  input  logic [BYTE_W-1:0]             rd_data,
  output logic                          rd_ready,
  input  logic                          next,
  output logic [NUM_FIELDS*FIELD_W-1:0] fields,
  output logic [OBJ_W-1:0]              obj_count,
  output logic [IDX_W-1:0]              byte_idx,
  output logic                          load_done,
  output logic                          loaded,
  output logic                          finish,
  output logic                          abort,
  output logic                          underflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  gr_state_e state_q, state_d;

  logic [NUM_FIELDS*FIELD_W-1:0] fields_d, bank_fields;
  logic [OBJ_W-1:0]              obj_d, bank_obj;
  logic [IDX_W-1:0]              byte_idx_d;
  logic loaded_d, load_done_d, finish_d, abort_d, underflow_d;
  logic shadow_wr, shadow_clr;

  assign rd_ready = ~status;

  gr_shadow_bank #(
    .TOTAL (TOTAL),
    .IDX_W (IDX_W),
    .OBJ_W (OBJ_W)
  ) u_shadow (
    .ACLK         (ACLK),
    .reset        (reset),
    .wr_en        (shadow_wr),
    .wr_idx       (byte_idx),
    .wr_data      (rd_data),
    .clr          (shadow_clr),
    .rd_obj_count (bank_obj),
    .rd_fields    (bank_fields)
  );

  always_comb begin
    state_d     = status ? ST_RENDER : ST_LOAD;
    byte_idx_d  = byte_idx;
    fields_d    = fields;
    obj_d       = obj_count;
    loaded_d    = loaded;
    load_done_d = 1'b0;
    abort_d     = 1'b0;
    underflow_d = 1'b0;
    shadow_wr   = 1'b0;
    shadow_clr  = 1'b0;

    if (status) begin
      // Leaving load mode with a partial header throws the partial bytes away.
      if (state_q == ST_LOAD && byte_idx != '0) begin
        abort_d    = 1'b1;
        byte_idx_d = '0;
        shadow_clr = 1'b1;
      end
      if (next) begin
        if (obj_count != '0) begin
          obj_d = obj_count - OBJ_W'(1);
        end else begin
          underflow_d = 1'b1;
        end
      end
    end else if (rd_valid) begin
      shadow_wr = 1'b1;
      if (byte_idx == LAST_IDX) begin
        fields_d    = bank_fields;
        obj_d       = bank_obj;
        byte_idx_d  = '0;
        loaded_d    = 1'b1;
        load_done_d = 1'b1;
      end else begin
        byte_idx_d = byte_idx + IDX_W'(1);
      end
    end

    finish_d = loaded_d && (obj_d == '0);
  end

  always_ff @(posedge ACLK) begin
    if (reset) begin
      state_q   <= ST_LOAD;
      byte_idx  <= '0;
      fields    <= '0;
      obj_count <= '0;
      loaded    <= 1'b0;
      load_done <= 1'b0;
      finish    <= 1'b0;
      abort     <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_idx  <= byte_idx_d;
      fields    <= fields_d;
      obj_count <= obj_d;
      loaded    <= loaded_d;
      load_done <= load_done_d;
      finish    <= finish_d;
      abort     <= abort_d;
      underflow <= underflow_d;
    end
  end

endmodule

// File: tb/tb_global_param_regs.sv
// Bench for global_param_regs: queue-based header model for the default
// configuration plus directed checks on a 2-byte-field configuration.
module tb_global_param_regs;

  logic ACLK = 1'b0;
  logic reset = 1'b1;
  always #5 ACLK = ~ACLK;

  logic        status, rd_valid, next, rd_ready;
  logic [7:0]  rd_data;
  logic [31:0] fields;
  logic [7:0]  obj_count;
  logic [2:0]  byte_idx;
  logic        load_done, loaded, finish, abort, underflow;

  logic        b_status, b_rd_valid, b_next, b_rd_ready;
  logic [7:0]  b_rd_data;
  logic [31:0] b_fields;
  logic [15:0] b_obj_count;
  logic [2:0]  b_byte_idx;
  logic        b_load_done, b_loaded, b_finish, b_abort, b_underflow;

  int errors = 0;
  int checks = 0;

  global_param_regs dut (
    .ACLK(ACLK), .reset(reset), .status(status), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_ready(rd_ready), .next(next), .fields(fields),
    .obj_count(obj_count), .byte_idx(byte_idx), .load_done(load_done),
    .loaded(loaded), .finish(finish), .abort(abort), .underflow(underflow)
  );

  global_param_regs #(
    .NUM_FIELDS(2), .FIELD_BYTES(2), .CNT_BYTES(2)
  ) dut_b (
    .ACLK(ACLK), .reset(reset), .status(b_status), .rd_valid(b_rd_valid),
    .rd_data(b_rd_data), .rd_ready(b_rd_ready), .next(b_next), .fields(b_fields),
    .obj_count(b_obj_count), .byte_idx(b_byte_idx), .load_done(b_load_done),
    .loaded(b_loaded), .finish(b_finish), .abort(b_abort), .underflow(b_underflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: header bytes collect in a queue; a full queue becomes the committed values.
  logic [7:0]  hdr[$];
  int unsigned m_count;
  logic [31:0] m_fields;
  bit m_loaded, m_done, m_finish, m_abort, m_under;
  bit model_on = 1'b0;

  always @(posedge ACLK) begin
    if (reset) begin
      hdr.delete();
      m_count = 0; m_fields = '0;
      m_loaded = 0; m_done = 0; m_finish = 0; m_abort = 0; m_under = 0;
      model_on = 1'b1;
    end else begin
      m_done = 0; m_abort = 0; m_under = 0;
      if (status) begin
        if (hdr.size() != 0) begin
          m_abort = 1;
          hdr.delete();
        end
        if (next) begin
          if (m_count > 0) m_count--;
          else m_under = 1;
        end
      end else if (rd_valid) begin
        hdr.push_back(rd_data);
        if (hdr.size() == 5) begin
          m_count  = hdr[0];
          m_fields = {hdr[4], hdr[3], hdr[2], hdr[1]};
          m_loaded = 1; m_done = 1;
          hdr.delete();
        end
      end
      m_finish = m_loaded && (m_count == 0);
    end
  end

  always @(negedge ACLK) begin
    if (model_on) begin
      chk("m_obj_count", obj_count, m_count);
      chk("m_fields", fields, m_fields);
      chk("m_byte_idx", byte_idx, hdr.size());
      chk("m_load_done", load_done, m_done);
      chk("m_loaded", loaded, m_loaded);
      chk("m_finish", finish, m_finish);
      chk("m_abort", abort, m_abort);
      chk("m_underflow", underflow, m_under);
      chk("m_rd_ready", rd_ready, !status);
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    rd_valid = 1'b1; rd_data = b;
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    b_rd_valid = 1'b1; b_rd_data = b;
    tick();
    b_rd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b2b [10];
    b2b = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88};
    status = 0; rd_valid = 0; rd_data = 0; next = 0;
    b_status = 0; b_rd_valid = 0; b_rd_data = 0; b_next = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    tick();
    chk("rst_fields", fields, 32'h0);
    chk("rst_obj", obj_count, 8'h0);
    chk("rst_loaded", loaded, 1'b0);
    chk("rst_finish", finish, 1'b0);

    // First header
    send(8'h03); send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    chk("load_obj", obj_count, 8'd3);
    chk("load_fields", fields, 32'h40302010);
    chk("load_done", load_done, 1'b1);
    chk("load_loaded", loaded, 1'b1);
    chk("load_finish", finish, 1'b0);
    tick();
    chk("load_done_drop", load_done, 1'b0);

    // Render countdown and underflow
    status = 1;
    for (int i = 0; i < 3; i++) begin
      next = 1;
      tick();
      chk("render_obj", obj_count, 8'(2 - i));
      chk("render_finish", finish, (i == 2));
    end
    tick();
    chk("underflow_pulse", underflow, 1'b1);
    chk("underflow_obj", obj_count, 8'd0);
    next = 0;
    tick();
    chk("underflow_drop", underflow, 1'b0);

    // Partial header then abort
    status = 0;
    send(8'h07); send(8'h55);
    chk("partial_idx", byte_idx, 3'd2);
    chk("partial_fields", fields, 32'h40302010);
    status = 1;
    tick();
    chk("abort_pulse", abort, 1'b1);
    chk("abort_idx", byte_idx, 3'd0);
    chk("abort_fields", fields, 32'h40302010);
    chk("abort_obj", obj_count, 8'd0);
    chk("abort_loaded", loaded, 1'b1);
    tick();
    chk("abort_drop", abort, 1'b0);

    // Back-to-back headers; second has count 0
    status = 0;
    for (int i = 0; i < 10; i++) begin
      send(b2b[i]);
      if (i == 4) begin
        chk("b2b_done1", load_done, 1'b1);
        chk("b2b_obj1", obj_count, 8'd2);
        chk("b2b_finish1", finish, 1'b0);
      end else if (i == 9) begin
        chk("b2b_done2", load_done, 1'b1);
        chk("b2b_finish2", finish, 1'b1);
        chk("b2b_fields2", fields, 32'h88776655);
      end else if (i > 4) begin
        chk("b2b_gap", load_done, 1'b0);
      end
    end

    // Reset in the middle of a header
    send(8'h01); send(8'h02); send(8'h03);
    chk("mid_idx", byte_idx, 3'd3);
    reset = 1;
    tick();
    chk("mrst_idx", byte_idx, 3'd0);
    chk("mrst_fields", fields, 32'h0);
    chk("mrst_obj", obj_count, 8'h0);
    chk("mrst_loaded", loaded, 1'b0);
    chk("mrst_finish", finish, 1'b0);
    chk("mrst_abort", abort, 1'b0);
    reset = 0;
    tick();
    chk("mrst_abort2", abort, 1'b0);

    // Wide-field configuration
    send_b(8'h00); send_b(8'h01); send_b(8'h34);
    chk("b_partial_idx", b_byte_idx, 3'd3);
    chk("b_partial_fields", b_fields, 32'h0);
    send_b(8'h12); send_b(8'h78); send_b(8'h56);
    chk("b_obj", b_obj_count, 16'h0100);
    chk("b_field0", b_fields[15:0], 16'h1234);
    chk("b_field1", b_fields[31:16], 16'h5678);
    chk("b_load_done", b_load_done, 1'b1);
    chk("b_loaded", b_loaded, 1'b1);
    chk("b_finish", b_finish, 1'b0);
    chk("b_idx", b_byte_idx, 3'd0);
    chk("b_rd_ready", b_rd_ready, 1'b1);
    chk("b_abort", b_abort, 1'b0);
    chk("b_underflow", b_underflow, 1'b0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
